// File: rtl/ssp_rx.sv
// ssp_rx: receive side of the SSP serial link.
// Oversamples sspclkin/sspfssin/ssprxd in the clk_i domain, deserialises
// MSB-first bytes after a frame-sync pulse and queues them in a 4-entry
// first-word-fall-through FIFO with sticky overrun and framing-error flags.
module ssp_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       do_read,
  output logic [7:0] rx_d,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       rx_overrun,
  output logic       frame_err,
  input  logic       clr_err,
  input  logic       sspclkin,
  input  logic       sspfssin,
  input  logic       ssprxd
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Synchroniser chains; bit 0 is the stage closest to the pins.
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] fss_sync;
  logic [SYNC_STAGES-1:0] rxd_sync;
  logic                   clk_dly;

  logic clk_s;
  logic fss_s;
  logic rxd_s;
  logic rise_evt;
  logic fall_evt;

  // Registered edge events with their aligned frame-sync and data samples.
  logic rise_q;
  logic fall_q;
  logic fss_q;
  logic rxd_q;

  // Deserialiser state.
  state_t     state;
  state_t     state_n;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_n;
  logic       pend;
  logic       pend_n;
  logic [7:0] shreg;
  logic [7:0] shreg_n;
  logic       push_q;
  logic       push_n;
  logic [7:0] push_data_q;
  logic [7:0] push_data_n;
  logic       ferr_evt;

  // FIFO storage and bookkeeping.
  logic [7:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       pop;
  logic       push_ok;
  logic       overflow;

  // Bring the three serial inputs into clk_i, plus one extra clock flop for edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync <= '0;
      fss_sync <= '0;
      rxd_sync <= '0;
      clk_dly  <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], sspclkin};
      fss_sync <= {fss_sync[SYNC_STAGES-2:0], sspfssin};
      rxd_sync <= {rxd_sync[SYNC_STAGES-2:0], ssprxd};
      clk_dly  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign fss_s    = fss_sync[SYNC_STAGES-1];
  assign rxd_s    = rxd_sync[SYNC_STAGES-1];
  assign rise_evt = clk_s & ~clk_dly;
  assign fall_evt = ~clk_s & clk_dly;

  // Register the one-cycle edge events together with the samples they qualify.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      fss_q  <= 1'b0;
      rxd_q  <= 1'b0;
    end else begin
      rise_q <= rise_evt;
      fall_q <= fall_evt;
      fss_q  <= fss_s;
      rxd_q  <= rxd_s;
    end
  end

  // Deserialiser state register, including the outgoing push strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      pend        <= 1'b0;
      shreg       <= 8'h00;
      push_q      <= 1'b0;
      push_data_q <= 8'h00;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      pend        <= pend_n;
      shreg       <= shreg_n;
      push_q      <= push_n;
      push_data_q <= push_data_n;
    end
  end

  // Next-state logic: start on a framed rising edge, shift on falling edges.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    pend_n      = pend;
    shreg_n     = shreg;
    push_n      = 1'b0;
    push_data_n = push_data_q;
    ferr_evt    = 1'b0;
    case (state)
      IDLE: begin
        if (rise_q && fss_q) begin
          state_n   = SHIFT;
          bit_cnt_n = 3'd0;
          pend_n    = 1'b0;
        end
      end
      SHIFT: begin
        if (rise_q && fss_q) begin
          if (bit_cnt == 3'd7) begin
            pend_n = 1'b1;
          end else begin
            ferr_evt = 1'b1;
          end
        end
        if (fall_q) begin
          shreg_n = {shreg[6:0], rxd_q};
          if (bit_cnt == 3'd7) begin
            push_n      = 1'b1;
            push_data_n = {shreg[6:0], rxd_q};
            bit_cnt_n   = 3'd0;
            if (pend) begin
              pend_n = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // A read frees a slot before the push is considered, so a full FIFO can
  // accept a byte in the same cycle it is read.
  assign pop      = do_read && (count != 3'd0);
  assign push_ok  = push_q && ((count != 3'd4) || pop);
  assign overflow = push_q && (count == 3'd4) && !pop;

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] <= 8'h00;
      end
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data_q;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (overflow) begin
        rx_overrun <= 1'b1;
      end else if (clr_err) begin
        rx_overrun <= 1'b0;
      end
      if (ferr_evt) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end
    end
  end

  assign rx_d     = mem[rd_ptr];
  assign rx_empty = (count == 3'd0);
  assign rx_full  = (count == 3'd4);

endmodule

// File: tb/tb_ssp_rx.sv
// tb_ssp_rx: self-checking bench for ssp_rx.
// Drives SSP frames at sspclkin = clk_i/8 and checks received bytes and flags
// against a table of vectors, hand-written corner sequences and a randomized
// run compared with a queue of the bytes transmitted.
module tb_ssp_rx;

  localparam int SYNC_STAGES = 2;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       do_read;
  logic [7:0] rx_d;
  logic       rx_empty;
  logic       rx_full;
  logic       rx_overrun;
  logic       frame_err;
  logic       clr_err;
  logic       sspclkin;
  logic       sspfssin;
  logic       ssprxd;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0] data;
    int         err_bit;
    logic [7:0] exp_d;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [6];
  logic [7:0] exp_q [$];

  ssp_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .do_read    (do_read),
    .rx_d       (rx_d),
    .rx_empty   (rx_empty),
    .rx_full    (rx_full),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err),
    .clr_err    (clr_err),
    .sspclkin   (sspclkin),
    .sspfssin   (sspfssin),
    .ssprxd     (ssprxd)
  );

  always #5 clk_i = ~clk_i;

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One sspclkin period: rise, new fss/data one clk later, 4-clk high and low
  // phases. Optionally pulse do_read right as the byte of this period is pushed.
  task automatic applyStimulus(input logic f, input logic d, input logic pop);
    sspclkin = 1'b1;
    @(negedge clk_i);
    sspfssin = f;
    ssprxd   = d;
    repeat (3) @(negedge clk_i);
    sspclkin = 1'b0;
    repeat (4) @(negedge clk_i);
    if (pop) begin
      do_read = 1'b1;
      @(negedge clk_i);
      do_read = 1'b0;
    end
  endtask

  // Frame: optional sync period, then 8 bits MSB first; fss may be raised
  // during bit err_bit (framing error) or during bit 8 (back-to-back).
  task automatic send_frame(input logic [7:0] b, input int err_bit, input logic lead,
                            input logic tail, input logic pop_last);
    if (lead) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus((i == err_bit) || (i == 8 && tail), b[8-i], (i == 8) && pop_last);
    end
  endtask

  task automatic wait_not_empty(input string name);
    int n = 0;
    while (rx_empty && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput(name, rx_empty, 1'b0);
  endtask

  task automatic read_pulse();
    do_read = 1'b1;
    @(negedge clk_i);
    do_read = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    @(negedge clk_i);
    clr_err = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    logic [7:0] b;
    logic       prev_tail;
    logic       tail;
    int         n;

    vecs[0] = '{8'hA5, 0, 8'hA5, 1'b0};
    vecs[1] = '{8'hF0, 3, 8'hF0, 1'b1};
    vecs[2] = '{8'h00, 0, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 0, 8'hFF, 1'b0};
    vecs[4] = '{8'h81, 1, 8'h81, 1'b1};
    vecs[5] = '{8'h7E, 6, 8'h7E, 1'b1};

    rst_i    = 1'b1;
    do_read  = 1'b0;
    clr_err  = 1'b0;
    sspclkin = 1'b0;
    sspfssin = 1'b0;
    ssprxd   = 1'b0;
    idle_cycles(3);
    checkOutput("reset_empty", rx_empty, 1'b1);
    checkOutput("reset_full", rx_full, 1'b0);
    checkOutput("reset_rx_d", rx_d, 8'h00);
    checkOutput("reset_overrun", rx_overrun, 1'b0);
    checkOutput("reset_frame_err", frame_err, 1'b0);
    rst_i = 1'b0;
    idle_cycles(2);

    // Single byte A5 with exact receive latency on the 8th falling edge.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) applyStimulus(1'b0, vecs[0].data[8-i], 1'b0);
    sspclkin = 1'b1;
    @(negedge clk_i);
    ssprxd = 1'b1;
    repeat (3) @(negedge clk_i);
    sspclkin = 1'b0;
    repeat (4) @(negedge clk_i);
    checkOutput("latency_not_early", rx_empty, 1'b1);
    @(negedge clk_i);
    checkOutput("latency_on_time", rx_empty, 1'b0);
    checkOutput("latency_data", rx_d, 8'hA5);
    read_pulse();
    checkOutput("latency_read_empty", rx_empty, 1'b1);
    idle_cycles(4);

    // Table-driven single frames, some with a mid-byte frame sync.
    foreach (vecs[k]) begin
      send_frame(vecs[k].data, vecs[k].err_bit, 1'b1, 1'b0, 1'b0);
      wait_not_empty($sformatf("vec%0d_ready", k));
      checkOutput($sformatf("vec%0d_data", k), rx_d, vecs[k].exp_d);
      checkOutput($sformatf("vec%0d_frame_err", k), frame_err, vecs[k].exp_ferr);
      checkOutput($sformatf("vec%0d_full", k), rx_full, 1'b0);
      read_pulse();
      checkOutput($sformatf("vec%0d_empty", k), rx_empty, 1'b1);
      clr_pulse();
      checkOutput($sformatf("vec%0d_ferr_clr", k), frame_err, 1'b0);
    end

    // Back-to-back frames: fss raised during bit 8 of the first.
    send_frame(8'h3C, 0, 1'b1, 1'b1, 1'b0);
    send_frame(8'hC3, 0, 1'b0, 1'b0, 1'b0);
    idle_cycles(4);
    checkOutput("b2b_first", rx_d, 8'h3C);
    read_pulse();
    checkOutput("b2b_second", rx_d, 8'hC3);
    checkOutput("b2b_second_valid", rx_empty, 1'b0);
    read_pulse();
    checkOutput("b2b_empty", rx_empty, 1'b1);
    checkOutput("b2b_frame_err", frame_err, 1'b0);

    // Overrun: five bytes with no reads.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 1'b1, 1'b0, 1'b0);
    idle_cycles(4);
    checkOutput("ovr_full", rx_full, 1'b1);
    checkOutput("ovr_flag", rx_overrun, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("ovr_read%0d", i), rx_d, 8'(i));
      read_pulse();
    end
    checkOutput("ovr_empty", rx_empty, 1'b1);
    checkOutput("ovr_still_sticky", rx_overrun, 1'b1);
    clr_pulse();
    checkOutput("ovr_clr", rx_overrun, 1'b0);

    // Full FIFO with a read in the exact push cycle of the fifth byte.
    send_frame(8'h11, 0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h33, 0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h44, 0, 1'b1, 1'b0, 1'b0);
    idle_cycles(4);
    checkOutput("pp_full_before", rx_full, 1'b1);
    send_frame(8'h55, 0, 1'b1, 1'b0, 1'b1);
    idle_cycles(4);
    checkOutput("pp_no_overrun", rx_overrun, 1'b0);
    checkOutput("pp_full_after", rx_full, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      checkOutput($sformatf("pp_read%0d", i), rx_d, 8'(i * 8'h11));
      read_pulse();
    end
    checkOutput("pp_empty", rx_empty, 1'b1);

    // Reset mid-byte with a byte already queued, then a fresh frame.
    send_frame(8'h5A, 0, 1'b1, 1'b0, 1'b0);
    idle_cycles(4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    rst_i = 1'b1;
    idle_cycles(2);
    checkOutput("mid_rst_empty", rx_empty, 1'b1);
    checkOutput("mid_rst_full", rx_full, 1'b0);
    checkOutput("mid_rst_rx_d", rx_d, 8'h00);
    checkOutput("mid_rst_overrun", rx_overrun, 1'b0);
    checkOutput("mid_rst_frame_err", frame_err, 1'b0);
    rst_i = 1'b0;
    idle_cycles(2);
    send_frame(8'h81, 0, 1'b1, 1'b0, 1'b0);
    wait_not_empty("mid_rst_ready");
    checkOutput("mid_rst_data", rx_d, 8'h81);
    read_pulse();
    checkOutput("mid_rst_only_one", rx_empty, 1'b1);
    checkOutput("mid_rst_no_ferr", frame_err, 1'b0);

    // Randomized bursts of up to 4 frames with random back-to-back and gaps;
    // expected output is simply the transmitted byte sequence.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 4);
      prev_tail = 1'b0;
      for (int j = 0; j < n; j++) begin
        b    = 8'($urandom);
        tail = (j < n - 1) && ($urandom_range(0, 1) == 1);
        exp_q.push_back(b);
        send_frame(b, 0, !prev_tail, tail, 1'b0);
        if (!tail) begin
          for (int g = 0; g < int'($urandom_range(0, 2)); g++) applyStimulus(1'b0, 1'b0, 1'b0);
        end
        prev_tail = tail;
      end
      while (exp_q.size() > 0) begin
        wait_not_empty($sformatf("rnd%0d_ready", r));
        checkOutput($sformatf("rnd%0d_data", r), rx_d, exp_q.pop_front());
        idle_cycles($urandom_range(0, 3));
        read_pulse();
      end
      checkOutput($sformatf("rnd%0d_empty", r), rx_empty, 1'b1);
      checkOutput($sformatf("rnd%0d_overrun", r), rx_overrun, 1'b0);
      checkOutput($sformatf("rnd%0d_frame_err", r), frame_err, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Bound the whole run so a stuck design cannot hang the bench.
  initial begin
    #2000000;
    tests_failed++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
